// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the uart_bridge register front end: register map,
// STATUS bit positions and TX launch FSM encoding.
package uart_bridge_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV_LO = 2'd2;
  localparam logic [1:0] ADDR_DIV_HI = 2'd3;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_TX_IDLE  = 4;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_LAUNCH  = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_e;

  function automatic logic [7:0] pack_status(input logic tx_idle,
                                             input logic overrun,
                                             input logic tx_empty,
                                             input logic tx_full,
                                             input logic rx_avail);
    return {3'b000, tx_idle, overrun, tx_empty, tx_full, rx_avail};
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with fall-through head; extra pointer MSB tells full
// from empty. A push into a full FIFO only lands when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bridge.sv
// CPU-side front end for uart_core: byte register map, TX/RX FIFOs, TX launch
// handshake, RX capture/ack and the 12-bit baud divider.
module uart_bridge
  import uart_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [11:0] DEFAULT_DIVIDER = 12'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic [11:0] divider,
  output logic [7:0]  core_data_tx,
  output logic        core_have_tx,
  input  logic        core_transmitting,
  input  logic [7:0]  core_data_rx,
  input  logic        core_have_rx,
  output logic        core_rx_ack,
  output logic        irq
);

  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [11:0] div_q, div_d;
  logic [7:0]  data_tx_q, data_tx_d;
  logic        rx_ack_q, rx_ack_d;
  logic        overrun_q, overrun_d;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic       rx_capture, tx_idle;
  logic       wr_data, wr_status, wr_div_lo, wr_div_hi, rd_data;

  assign wr_data   = bus_wr && (bus_addr == ADDR_DATA);
  assign wr_status = bus_wr && (bus_addr == ADDR_STATUS);
  assign wr_div_lo = bus_wr && (bus_addr == ADDR_DIV_LO);
  assign wr_div_hi = bus_wr && (bus_addr == ADDR_DIV_HI);
  assign rd_data   = bus_rd && (bus_addr == ADDR_DATA);

  assign tx_push    = wr_data;
  assign rx_capture = core_have_rx && !rx_ack_q;
  assign rx_push    = rx_capture;
  assign rx_pop     = rd_data && !rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus_wdata),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (core_data_rx),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // The byte is latched on entry to LAUNCH; the FIFO pops at the end of LAUNCH.
  always_comb begin
    tx_state_d = tx_state_q;
    data_tx_d  = data_tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !core_transmitting) begin
          tx_state_d = TX_LAUNCH;
          data_tx_d  = tx_head;
        end
      end
      TX_LAUNCH: begin
        tx_pop     = 1'b1;
        tx_state_d = TX_WAIT_HI;
      end
      TX_WAIT_HI: if (core_transmitting) tx_state_d = TX_WAIT_LO;
      TX_WAIT_LO: if (!core_transmitting) tx_state_d = TX_IDLE;
      default:    tx_state_d = TX_IDLE;
    endcase
  end

  assign tx_idle = (tx_state_q == TX_IDLE) && !core_transmitting;

  // Reads see pre-write register values, so a same-cycle write never leaks in.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      case (bus_addr)
        ADDR_DATA:   rdata_d = rx_empty ? 8'h00 : rx_head;
        ADDR_STATUS: rdata_d = pack_status(tx_idle, overrun_q, tx_empty, tx_full, !rx_empty);
        ADDR_DIV_LO: rdata_d = div_q[7:0];
        ADDR_DIV_HI: rdata_d = {4'h0, div_q[11:8]};
      endcase
    end
  end

  always_comb begin
    div_d = div_q;
    if (wr_div_lo) div_d[7:0]  = bus_wdata;
    if (wr_div_hi) div_d[11:8] = bus_wdata[3:0];

    // A fresh overrun beats a same-cycle clear so no lost byte goes unreported.
    overrun_d = overrun_q;
    if (wr_status && bus_wdata[ST_OVERRUN]) overrun_d = 1'b0;
    if (rx_capture && rx_full && !rx_pop)   overrun_d = 1'b1;

    rx_ack_d = rx_capture;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      rdata_q    <= 8'h00;
      div_q      <= DEFAULT_DIVIDER;
      data_tx_q  <= 8'h00;
      rx_ack_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rdata_q    <= rdata_d;
      div_q      <= div_d;
      data_tx_q  <= data_tx_d;
      rx_ack_q   <= rx_ack_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus_rdata    = rdata_q;
  assign divider      = div_q;
  assign core_data_tx = data_tx_q;
  assign core_have_tx = (tx_state_q == TX_LAUNCH);
  assign core_rx_ack  = rx_ack_q;
  assign irq          = !rx_empty || (tx_empty && tx_idle);

endmodule

// File: tb/tb_uart_bridge.sv
// Bench for uart_bridge: directed scenarios plus random bus/core traffic, checked
// every cycle against a queue-based model of the FIFOs, registers and handshakes.
module tb_uart_bridge;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [7:0]  bus_wdata = 8'h00;
  logic [7:0]  bus_rdata;
  logic [11:0] divider;
  logic [7:0]  core_data_tx;
  logic        core_have_tx;
  logic        core_transmitting = 1'b0;
  logic [7:0]  core_data_rx = 8'h00;
  logic        core_have_rx = 1'b0;
  logic        core_rx_ack;
  logic        irq;

  always #5 clk = ~clk;

  uart_bridge #(.FIFO_DEPTH(D), .DEFAULT_DIVIDER(12'd103)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus_addr          (bus_addr),
    .bus_wr            (bus_wr),
    .bus_rd            (bus_rd),
    .bus_wdata         (bus_wdata),
    .bus_rdata         (bus_rdata),
    .divider           (divider),
    .core_data_tx      (core_data_tx),
    .core_have_tx      (core_have_tx),
    .core_transmitting (core_transmitting),
    .core_data_rx      (core_data_rx),
    .core_have_rx      (core_have_rx),
    .core_rx_ack       (core_rx_ack),
    .irq               (irq)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  launched[$];
  logic        m_ack, m_ov, m_inflight, m_seen_hi, rd_pend;
  logic [7:0]  rd_exp;
  logic [11:0] m_div;
  int          idle_cnt;

  // Core behaviour: transmitting is high for cycles c_from..c_to after a launch
  int cyc_no = 0;
  int c_from = 1;
  int c_to = 0;
  int c_dly_max = 0;
  int c_len_fix = 0;
  bit c_stall = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_ack      = 1'b0;
    m_ov       = 1'b0;
    m_inflight = 1'b0;
    m_seen_hi  = 1'b0;
    m_div      = 12'd103;
    idle_cnt   = 0;
  endtask

  // One clock cycle: apply core reactions, check outputs, advance model, clock.
  task automatic cyc();
    logic       tx_idle_now, pop_rx, cap, gap;
    logic [7:0] st;
    int         len;
    core_transmitting = (cyc_no >= c_from) && (cyc_no <= c_to);
    if (core_rx_ack) core_have_rx = 1'b0;
    #1;
    tx_idle_now = !(m_inflight || core_have_tx) && !core_transmitting;
    st = {3'b000, tx_idle_now, m_ov, txq.size() == 0, txq.size() == D, rxq.size() != 0};

    if (rd_pend) check("rdata", 16'(bus_rdata), 16'(rd_exp));
    check("rx_ack", 16'(core_rx_ack), 16'(m_ack));
    check("divider", 16'(divider), 16'(m_div));
    check("irq", 16'(irq), 16'((rxq.size() != 0) || (txq.size() == 0 && tx_idle_now)));
    if (core_have_tx) begin
      check("tx_launch_ok", 16'(txq.size() != 0 && !m_inflight && !core_transmitting), 16'd1);
      if (txq.size() != 0) check("tx_data", 16'(core_data_tx), 16'(txq[0]));
      launched.push_back(core_data_tx);
      len    = c_stall ? 1000000 : (c_len_fix != 0 ? c_len_fix : int'($urandom_range(1, 6)));
      c_from = cyc_no + 1 + int'($urandom_range(0, c_dly_max));
      c_to   = c_from + len - 1;
    end
    gap = (txq.size() != 0) && !m_inflight && !core_have_tx && !core_transmitting;
    idle_cnt = gap ? idle_cnt + 1 : 0;
    if (gap) check("tx_gap", 16'(idle_cnt <= 2), 16'd1);

    if (rst) begin
      model_reset();
      rd_pend = 1'b1;
      rd_exp  = 8'h00;
    end else begin
      rd_pend = bus_rd;
      if (bus_rd) begin
        case (bus_addr)
          2'd0: rd_exp = (rxq.size() != 0) ? rxq[0] : 8'h00;
          2'd1: rd_exp = st;
          2'd2: rd_exp = m_div[7:0];
          2'd3: rd_exp = {4'h0, m_div[11:8]};
        endcase
      end
      pop_rx = bus_rd && (bus_addr == 2'd0) && (rxq.size() != 0);
      if (core_have_tx && txq.size() != 0) void'(txq.pop_front());
      if (bus_wr && bus_addr == 2'd0 && txq.size() < D) txq.push_back(bus_wdata);
      cap = core_have_rx && !m_ack;
      if (pop_rx) void'(rxq.pop_front());
      if (bus_wr && bus_addr == 2'd1 && bus_wdata[3]) m_ov = 1'b0;
      if (cap) begin
        if (rxq.size() < D) rxq.push_back(core_data_rx);
        else m_ov = 1'b1;
      end
      if (bus_wr && bus_addr == 2'd2) m_div[7:0]  = bus_wdata;
      if (bus_wr && bus_addr == 2'd3) m_div[11:8] = bus_wdata[3:0];
      m_ack = cap;
      if (core_have_tx) begin
        m_inflight = 1'b1;
        m_seen_hi  = 1'b0;
      end else if (m_inflight) begin
        if (core_transmitting) m_seen_hi = 1'b1;
        else if (m_seen_hi) m_inflight = 1'b0;
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc_no++;
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    cyc();
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus_addr = a;
    bus_rd   = 1'b1;
    cyc();
    d = bus_rdata;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 600 && !(txq.size() == 0 && !m_inflight && cyc_no > c_to && !core_have_tx)) begin
      cyc();
      n++;
    end
    check("idle_reached", 16'(n < 600), 16'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int r, n;

    // Reset
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd_pend = 1'b1;
    rd_exp  = 8'h00;

    rd(2'd1, v); check("rst_status", 16'(v), 16'h0014);
    rd(2'd2, v); check("rst_div_lo", 16'(v), 16'h0067);
    rd(2'd3, v); check("rst_div_hi", 16'(v), 16'h0000);
    check("rst_irq", 16'(irq), 16'd1);
    check("rst_divider", 16'(divider), 16'd103);

    // Two frames, core busy 20 cycles each
    c_dly_max = 0;
    c_len_fix = 20;
    launched.delete();
    wr(2'd0, 8'h55);
    wr(2'd0, 8'hA3);
    n = 0;
    while (n < 200 && launched.size() < 2) begin cyc(); n++; end
    check("t2_launches", 16'(launched.size()), 16'd2);
    if (launched.size() == 2) begin
      check("t2_first", 16'(launched[0]), 16'h0055);
      check("t2_second", 16'(launched[1]), 16'h00A3);
    end
    wait_idle();
    rd(2'd1, v); check("t2_tx_empty", 16'(v[2]), 16'd1);

    // Stalled core: one launch, four queued, sixth write dropped
    c_stall = 1'b1;
    c_len_fix = 0;
    launched.delete();
    for (int i = 0; i < 6; i++) wr(2'd0, 8'(8'h10 + i));
    rd(2'd1, v);
    check("t3_tx_full", 16'(v[1]), 16'd1);
    check("t3_tx_idle", 16'(v[4]), 16'd0);
    check("t3_one_launch", 16'(launched.size()), 16'd1);
    c_stall = 1'b0;
    c_to = cyc_no - 1;
    wait_idle();
    check("t3_frames", 16'(launched.size()), 16'd5);
    if (launched.size() == 5) check("t3_last", 16'(launched[4]), 16'h0014);

    // Single RX byte
    core_data_rx = 8'h3C;
    core_have_rx = 1'b1;
    cyc();
    check("t4_ack", 16'(core_rx_ack), 16'd1);
    cyc();
    check("t4_ack_once", 16'(core_rx_ack), 16'd0);
    rd(2'd1, v); check("t4_rx_avail", 16'(v[0]), 16'd1);
    rd(2'd0, v); check("t4_data", 16'(v), 16'h003C);
    rd(2'd1, v); check("t4_rx_empty", 16'(v[0]), 16'd0);

    // RX overrun
    for (int i = 0; i < 5; i++) begin
      core_data_rx = 8'(8'hA0 + i);
      core_have_rx = 1'b1;
      cyc();
      cyc();
    end
    rd(2'd1, v); check("t5_overrun", 16'(v[3]), 16'd1);
    wr(2'd1, 8'h08);
    rd(2'd1, v); check("t5_ov_clear", 16'(v[3]), 16'd0);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, v);
      check("t5_rx_byte", 16'(v), 16'(8'hA0 + i));
    end
    rd(2'd0, v); check("t5_empty_read", 16'(v), 16'h0000);

    // Divider, then reset during WAIT_LO
    wr(2'd2, 8'h0F);
    wr(2'd3, 8'hF2);
    check("t6_divider", 16'(divider), 16'h020F);
    rd(2'd3, v); check("t6_div_hi", 16'(v), 16'h0002);
    c_stall = 1'b1;
    core_data_rx = 8'h99;
    core_have_rx = 1'b1;
    wr(2'd0, 8'h77);
    wr(2'd0, 8'h78);
    wr(2'd0, 8'h79);
    n = 0;
    while (n < 50 && !(m_inflight && m_seen_hi)) begin cyc(); n++; end
    check("t6_wait_lo", 16'(m_inflight && m_seen_hi), 16'd1);
    launched.delete();
    rst = 1'b1;
    cyc();
    rd(2'd1, v); check("t6_status", 16'(v), 16'h0004);
    check("t6_div_rst", 16'(divider), 16'd103);
    c_stall = 1'b0;
    c_to = cyc_no - 1;
    for (int i = 0; i < 10; i++) cyc();
    check("t6_no_launch", 16'(launched.size()), 16'd0);
    check("t6_irq", 16'(irq), 16'd1);

    // Random traffic
    c_dly_max = 2;
    c_len_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      bus_addr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus_wdata = 8'($urandom);
      bus_wr    = (r < 4) || (r == 8);
      bus_rd    = (r >= 4) && (r <= 8);
      if (!core_have_rx && $urandom_range(0, 5) == 0) begin
        core_have_rx = 1'b1;
        core_data_rx = 8'($urandom);
      end
      if (i == 1500) rst = 1'b1;
      cyc();
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
